// File: rtl/freg_file_sb_pkg.sv
// Shared definitions for the FP register file with scoreboard: scrub FSM encodings,
// default geometry and the index range helper.
package freg_file_sb_pkg;

    localparam int FREG_DATA_W_DEF   = 32;
    localparam int FREG_NUM_REGS_DEF = 32;
    localparam int FREG_ADDR_W_DEF   = 5;
    localparam int FREG_NUM_RD_DEF   = 3;
    localparam int FREG_DBG_SEL_W    = 5;

    typedef enum logic {
        FREG_ST_CLEAR = 1'b0,
        FREG_ST_RUN   = 1'b1
    } freg_state_e;

    // The register count need not be a power of two, so every index is range-checked.
    function automatic logic idx_in_range(input logic [31:0] idx, input logic [31:0] nregs);
        return (idx < nregs);
    endfunction

endpackage

// File: rtl/freg_file_sb_if.sv
// Datapath-side bundle of the FP register file: writeback, reads, issue/flush,
// scoreboard view and the two debug taps.
interface freg_file_sb_if
    import freg_file_sb_pkg::*;
#(
    parameter int DATA_W   = FREG_DATA_W_DEF,
    parameter int NUM_REGS = FREG_NUM_REGS_DEF,
    parameter int ADDR_W   = FREG_ADDR_W_DEF,
    parameter int NUM_RD   = FREG_NUM_RD_DEF
);

    logic                       iRegWrite;
    logic [ADDR_W-1:0]          iWriteRegister;
    logic [DATA_W-1:0]          iWriteData;
    logic [NUM_RD*ADDR_W-1:0]   iReadRegister;
    logic [NUM_RD*DATA_W-1:0]   oReadData;
    logic [NUM_RD-1:0]          oReadBusy;
    logic                       iIssue;
    logic [ADDR_W-1:0]          iIssueRegister;
    logic                       iFlush;
    logic                       oReady;
    logic [NUM_REGS-1:0]        oBusyVec;
    logic [FREG_DBG_SEL_W-1:0]  iVGASelect;
    logic [DATA_W-1:0]          oVGARead;
    logic [FREG_DBG_SEL_W-1:0]  iRegDispSelect;
    logic [DATA_W-1:0]          oRegDisp;

    modport master (
        output iRegWrite, iWriteRegister, iWriteData, iReadRegister,
               iIssue, iIssueRegister, iFlush, iVGASelect, iRegDispSelect,
        input  oReadData, oReadBusy, oReady, oBusyVec, oVGARead, oRegDisp
    );

    modport slave (
        input  iRegWrite, iWriteRegister, iWriteData, iReadRegister,
               iIssue, iIssueRegister, iFlush, iVGASelect, iRegDispSelect,
        output oReadData, oReadBusy, oReady, oBusyVec, oVGARead, oRegDisp
    );

endinterface

// File: rtl/freg_file_sb_scoreboard.sv
// Pending-result scoreboard: one busy bit per FP register, set by issue, cleared by
// writeback or flush, and looked up for every read port.
module freg_scoreboard
    import freg_file_sb_pkg::*;
#(
    parameter int NUM_REGS = FREG_NUM_REGS_DEF,
    parameter int ADDR_W   = FREG_ADDR_W_DEF,
    parameter int NUM_RD   = FREG_NUM_RD_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     run_i,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_idx_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_idx_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_idx_i,
    input  logic [NUM_RD-1:0]        bypass_hit_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [NUM_REGS-1:0]      busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                issue_ok_s;
    logic                wr_ok_s;
    logic [ADDR_W-1:0]   rd_idx_v;

    assign issue_ok_s = issue_i && idx_in_range(32'(issue_idx_i), 32'(NUM_REGS));
    assign wr_ok_s    = wr_en_i && idx_in_range(32'(wr_idx_i), 32'(NUM_REGS));

    // Next busy vector: flush beats everything, issue beats a same-index writeback.
    always_comb begin
        busy_d = busy_q;
        if (!run_i) begin
            busy_d = {NUM_REGS{1'b0}};
        end else if (flush_i) begin
            busy_d = {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue_ok_s && (issue_idx_i == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end else if (wr_ok_s && (wr_idx_i == ADDR_W'(i))) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
    end

    // Busy bit lookup per read port; a write-through hit already carries fresh data.
    always_comb begin
        rd_busy_o = {NUM_RD{1'b0}};
        rd_idx_v  = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_idx_v = rd_idx_i[k*ADDR_W +: ADDR_W];
            if (run_i && idx_in_range(32'(rd_idx_v), 32'(NUM_REGS)) && !bypass_hit_i[k]) begin
                rd_busy_o[k] = busy_q[rd_idx_v];
            end else begin
                rd_busy_o[k] = 1'b0;
            end
        end
    end

    // Busy state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/freg_file_sb.sv
// FP register file with post-reset zero scrub, async read ports, debug taps and an
// issue/writeback scoreboard. Define FREG_BYPASS_EN for same-cycle write-through reads.
module freg_file_sb
    import freg_file_sb_pkg::*;
#(
    parameter int DATA_W   = FREG_DATA_W_DEF,
    parameter int NUM_REGS = FREG_NUM_REGS_DEF,
    parameter int ADDR_W   = FREG_ADDR_W_DEF,
    parameter int NUM_RD   = FREG_NUM_RD_DEF
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    freg_file_sb_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    freg_state_e              state_q;
    freg_state_e              state_d;
    logic [ADDR_W-1:0]        cnt_q;
    logic [ADDR_W-1:0]        cnt_d;
    logic [DATA_W-1:0]        mem_q [NUM_REGS];

    logic                     run_s;
    logic                     wr_ok_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]        bypass_hit_s;
    logic [NUM_RD-1:0]        rd_busy_s;
    logic [NUM_REGS-1:0]      busy_vec_s;
    logic [DATA_W-1:0]        vga_data_s;
    logic [DATA_W-1:0]        disp_data_s;
    logic [ADDR_W-1:0]        rd_idx_v;

    assign run_s   = (state_q == FREG_ST_RUN);
    assign wr_ok_s = run_s && bus.iRegWrite
                     && idx_in_range(32'(bus.iWriteRegister), 32'(NUM_REGS));

    // Scrub sequencer: walk every index once, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FREG_ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = FREG_ST_RUN;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = FREG_ST_CLEAR;
                    cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            FREG_ST_RUN: begin
                state_d = FREG_ST_RUN;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = FREG_ST_CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Scrub FSM state and counter.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= FREG_ST_CLEAR;
            cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: no reset, zeroed by the scrub instead.
    always_ff @(posedge iCLK) begin
        if (state_q == FREG_ST_CLEAR) begin
            mem_q[cnt_q] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_q[bus.iWriteRegister] <= bus.iWriteData;
        end
    end

    // Operand read ports with optional write-through.
    always_comb begin
        rd_data_s    = {(NUM_RD*DATA_W){1'b0}};
        bypass_hit_s = {NUM_RD{1'b0}};
        rd_idx_v     = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_idx_v = bus.iReadRegister[k*ADDR_W +: ADDR_W];
            if (run_s && idx_in_range(32'(rd_idx_v), 32'(NUM_REGS))) begin
`ifdef FREG_BYPASS_EN
                if (wr_ok_s && (rd_idx_v == bus.iWriteRegister)) begin
                    rd_data_s[k*DATA_W +: DATA_W] = bus.iWriteData;
                    bypass_hit_s[k]               = 1'b1;
                end else begin
                    rd_data_s[k*DATA_W +: DATA_W] = mem_q[rd_idx_v];
                end
`else
                rd_data_s[k*DATA_W +: DATA_W] = mem_q[rd_idx_v];
`endif
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Debug taps follow the same gating and bypass rules as the operand ports.
    always_comb begin
        vga_data_s  = {DATA_W{1'b0}};
        disp_data_s = {DATA_W{1'b0}};
        if (run_s && idx_in_range(32'(bus.iVGASelect), 32'(NUM_REGS))) begin
`ifdef FREG_BYPASS_EN
            if (wr_ok_s && (32'(bus.iVGASelect) == 32'(bus.iWriteRegister))) begin
                vga_data_s = bus.iWriteData;
            end else begin
                vga_data_s = mem_q[bus.iVGASelect];
            end
`else
            vga_data_s = mem_q[bus.iVGASelect];
`endif
        end else begin
            vga_data_s = {DATA_W{1'b0}};
        end
        if (run_s && idx_in_range(32'(bus.iRegDispSelect), 32'(NUM_REGS))) begin
`ifdef FREG_BYPASS_EN
            if (wr_ok_s && (32'(bus.iRegDispSelect) == 32'(bus.iWriteRegister))) begin
                disp_data_s = bus.iWriteData;
            end else begin
                disp_data_s = mem_q[bus.iRegDispSelect];
            end
`else
            disp_data_s = mem_q[bus.iRegDispSelect];
`endif
        end else begin
            disp_data_s = {DATA_W{1'b0}};
        end
    end

    freg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk_i        (iCLK),
        .rst_ni       (iRST_N),
        .run_i        (run_s),
        .issue_i      (bus.iIssue),
        .issue_idx_i  (bus.iIssueRegister),
        .wr_en_i      (bus.iRegWrite),
        .wr_idx_i     (bus.iWriteRegister),
        .flush_i      (bus.iFlush),
        .rd_idx_i     (bus.iReadRegister),
        .bypass_hit_i (bypass_hit_s),
        .rd_busy_o    (rd_busy_s),
        .busy_vec_o   (busy_vec_s)
    );

    assign bus.oReadData = rd_data_s;
    assign bus.oReadBusy = rd_busy_s;
    assign bus.oBusyVec  = busy_vec_s;
    assign bus.oReady    = run_s;
    assign bus.oVGARead  = vga_data_s;
    assign bus.oRegDisp  = disp_data_s;

endmodule

// File: tb/tb_freg_file_sb.sv
// Self-checking bench for freg_file_sb: scrub timing, writeback/readback, scoreboard,
// flush, reset during scrub and the FREG_BYPASS_EN write-through behaviour.
module tb_freg_file_sb;
    import freg_file_sb_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 3;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] val;
    } exp_t;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    freg_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) bus ();

    freg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic idle();
        bus.iRegWrite      = 1'b0;
        bus.iWriteRegister = 5'd0;
        bus.iWriteData     = 32'h0;
        bus.iIssue         = 1'b0;
        bus.iIssueRegister = 5'd0;
        bus.iFlush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] idx);
        bus.iReadRegister[k*AW +: AW] = idx;
    endtask

    function automatic logic [DW-1:0] rd_port(input int k);
        return bus.oReadData[k*DW +: DW];
    endfunction

    task automatic test_reset();
        int n;
        iRST_N = 1'b0;
        idle();
        bus.iReadRegister  = '0;
        bus.iVGASelect     = 5'd0;
        bus.iRegDispSelect = 5'd0;
        repeat (3) tick();
        checks++;
        if (bus.oReady !== 1'b0 || bus.oBusyVec !== 32'h0 || bus.oReadData !== 96'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b busy=%h data=%h required 0/0/0",
                     bus.oReady, bus.oBusyVec, bus.oReadData);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        #1;
        n = 0;
        while (bus.oReady !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL scrub_len: ready after %0d cycles, required 32", n);
        end
        for (int i = 0; i < NR; i++) begin
            set_rd(0, AW'(i));
            #1;
            checks++;
            if (rd_port(0) !== 32'h0) begin
                failures++;
                $display("FAIL scrub_zero f%0d: got %h required 00000000", i, rd_port(0));
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [AW-1:0] idx_tab [5] = '{5'd0, 5'd31, 5'd17, 5'd8, 5'd30};
        logic [DW-1:0] val_tab [5] = '{32'hA5A50000, 32'h5A5AFFFF, 32'h00000001,
                                       32'h80000000, 32'hFFFFFFFF};
        int k;
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd5;
        bus.iWriteData = 32'h3F800000;
        exp_q.push_back('{5'd5, 32'h3F800000});
        tick();
        idle();
        set_rd(0, 5'd5);
        bus.iRegDispSelect = 5'd5;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rd_port(0) !== e.val || bus.oRegDisp !== e.val) begin
            failures++;
            $display("FAIL write_f5: port0=%h disp=%h required %h", rd_port(0), bus.oRegDisp, e.val);
        end
        for (int i = 0; i < 5; i++) begin
            bus.iRegWrite = 1'b1;
            bus.iWriteRegister = idx_tab[i];
            bus.iWriteData = val_tab[i];
            exp_q.push_back('{idx_tab[i], val_tab[i]});
            tick();
        end
        idle();
        exp_q.push_back('{5'd5, 32'h3F800000});
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            set_rd(k % NRD, e.idx);
            bus.iVGASelect = e.idx;
            #1;
            checks++;
            if (rd_port(k % NRD) !== e.val || bus.oVGARead !== e.val) begin
                failures++;
                $display("FAIL readback f%0d port%0d: got %h vga %h required %h",
                         e.idx, k % NRD, rd_port(k % NRD), bus.oVGARead, e.val);
            end
            k++;
        end
    endtask

    task automatic test_issue_busy();
        bus.iIssue = 1'b1;
        bus.iIssueRegister = 5'd7;
        set_rd(2, 5'd7);
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.oReadBusy[2] !== 1'b1 || bus.oBusyVec[7] !== 1'b1) begin
                failures++;
                $display("FAIL busy_hold cyc%0d: rdbusy=%b vec7=%b required 1/1",
                         c, bus.oReadBusy[2], bus.oBusyVec[7]);
            end
            tick();
        end
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd7;
        bus.iWriteData = 32'h40000000;
        #1;
        checks++;
`ifdef FREG_BYPASS_EN
        if (bus.oReadBusy[2] !== 1'b0) begin
`else
        if (bus.oReadBusy[2] !== 1'b1) begin
`endif
            failures++;
            $display("FAIL busy_wb_cycle: rdbusy=%b wrong for write cycle", bus.oReadBusy[2]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.oReadBusy[2] !== 1'b0 || bus.oBusyVec !== 32'h0 || rd_port(2) !== 32'h40000000) begin
            failures++;
            $display("FAIL busy_clear: rdbusy=%b vec=%h data=%h required 0/00000000/40000000",
                     bus.oReadBusy[2], bus.oBusyVec, rd_port(2));
        end
    endtask

    task automatic test_issue_write_flush();
        bus.iIssue = 1'b1;
        bus.iIssueRegister = 5'd3;
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd3;
        bus.iWriteData = 32'h12345678;
        set_rd(0, 5'd3);
        tick();
        idle();
        #1;
        checks++;
        if (rd_port(0) !== 32'h12345678 || bus.oReadBusy[0] !== 1'b1 || bus.oBusyVec !== 32'h00000008) begin
            failures++;
            $display("FAIL issue_wins: data=%h rdbusy=%b vec=%h required 12345678/1/00000008",
                     rd_port(0), bus.oReadBusy[0], bus.oBusyVec);
        end
        bus.iIssue = 1'b1;
        bus.iIssueRegister = 5'd5;
        tick();
        idle();
        checks++;
        if (bus.oBusyVec !== 32'h00000028) begin
            failures++;
            $display("FAIL issue_second: vec=%h required 00000028", bus.oBusyVec);
        end
        bus.iFlush = 1'b1;
        bus.iIssue = 1'b1;
        bus.iIssueRegister = 5'd4;
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd6;
        bus.iWriteData = 32'hCAFEF00D;
        tick();
        idle();
        set_rd(1, 5'd6);
        #1;
        checks++;
        if (bus.oBusyVec !== 32'h0 || rd_port(1) !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL flush: vec=%h f6=%h required 00000000/cafef00d", bus.oBusyVec, rd_port(1));
        end
    endtask

    task automatic test_reset_mid_scrub();
        int n;
        @(negedge iCLK);
        iRST_N = 1'b0;
        #2;
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (10) tick();
        #2;
        iRST_N = 1'b0;
        #1;
        checks++;
        if (bus.oReady !== 1'b0) begin
            failures++;
            $display("FAIL midscrub_ready: ready=%b required 0", bus.oReady);
        end
        #1;
        iRST_N = 1'b1;
        n = 0;
        while (bus.oReady !== 1'b1 && n < 100) begin
            if (n == 5) begin
                bus.iRegWrite = 1'b1;
                bus.iWriteRegister = 5'd2;
                bus.iWriteData = 32'hFFFFFFFF;
                bus.iIssue = 1'b1;
                bus.iIssueRegister = 5'd2;
                set_rd(0, 5'd2);
                bus.iVGASelect = 5'd5;
                #1;
                checks++;
                if (rd_port(0) !== 32'h0 || bus.oVGARead !== 32'h0 || bus.oReadBusy !== 3'b000) begin
                    failures++;
                    $display("FAIL clear_outputs: port0=%h vga=%h rdbusy=%b required 0/0/0",
                             rd_port(0), bus.oVGARead, bus.oReadBusy);
                end
            end
            if (n == 6) begin
                idle();
            end
            tick();
            n++;
        end
        idle();
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL rescrub_len: ready after %0d cycles, required 32", n);
        end
        set_rd(0, 5'd2);
        set_rd(1, 5'd5);
        #1;
        checks++;
        if (rd_port(0) !== 32'h0 || rd_port(1) !== 32'h0 || bus.oBusyVec !== 32'h0) begin
            failures++;
            $display("FAIL clear_write_lost: f2=%h f5=%h vec=%h required 0/0/0",
                     rd_port(0), rd_port(1), bus.oBusyVec);
        end
    endtask

    task automatic test_bypass();
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd9;
        bus.iWriteData = 32'h11111111;
        tick();
        idle();
        bus.iIssue = 1'b1;
        bus.iIssueRegister = 5'd9;
        tick();
        idle();
        bus.iRegWrite = 1'b1;
        bus.iWriteRegister = 5'd9;
        bus.iWriteData = 32'hDEADBEEF;
        set_rd(1, 5'd9);
        bus.iRegDispSelect = 5'd9;
        #1;
        checks++;
`ifdef FREG_BYPASS_EN
        if (rd_port(1) !== 32'hDEADBEEF || bus.oReadBusy[1] !== 1'b0 || bus.oRegDisp !== 32'hDEADBEEF) begin
`else
        if (rd_port(1) !== 32'h11111111 || bus.oReadBusy[1] !== 1'b1 || bus.oRegDisp !== 32'h11111111) begin
`endif
            failures++;
            $display("FAIL bypass_same_cycle: port1=%h busy=%b disp=%h",
                     rd_port(1), bus.oReadBusy[1], bus.oRegDisp);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_port(1) !== 32'hDEADBEEF || bus.oReadBusy[1] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_after: port1=%h busy=%b required deadbeef/0",
                     rd_port(1), bus.oReadBusy[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_issue_busy();
        test_issue_write_flush();
        test_bypass();
        test_reset_mid_scrub();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
